// File: rtl/ysyx_25020047_sram_resp.sv
// ysyx_25020047_sram_resp
// Word-addressed data-memory responder sitting at the target end of the LSU
// load/store interface. One request is accepted at a time on a valid/ready
// channel. After a programmable wait the read or byte-masked write is performed
// on the internal array, and the result is returned on a valid/ready response
// channel.
//
// Optional feature: define YSYX_25020047_SRAM_RAND_LAT_EN to add 0..3 extra
// wait cycles per transaction. The extra cycles come from a free-running 8-bit
// LFSR, so the LSU sees varying latency.
//
// Timing: when a request is accepted on edge T0, the access is performed and
// the response is raised on edge T0+1+wait. The wait is the value the counter
// was loaded with.

module ysyx_25020047_sram_resp #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W = $clog2(DEPTH);
    // Byte span of the array. It is 33 bits wide so that the compare cannot
    // wrap even for a very large DEPTH.
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state;
    // The counter is 9 bits so that LATENCY plus the random extra (up to 255+3)
    // fits.
    logic [8:0]       cnt;
    logic [8:0]       load_cnt;

    // The request is decoded when it is accepted. Only the range flag and the
    // word index are kept, not the whole byte address.
    logic             wen_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wmask_q;
    logic             in_range_q;
    logic [IDX_W-1:0] idx_q;

    logic             req_in_range;
    logic [IDX_W-1:0] req_idx;
    logic             accept;
    logic             do_access;

    logic [31:0]      mem [DEPTH];

    // The request side is open only while idle. This also holds it closed
    // during the response handshake cycle.
    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign accept    = req_valid & req_ready;

    // The access happens on the edge that leaves WAIT with the counter
    // exhausted.
    assign do_access = (state == S_WAIT) && (cnt == 9'd0);

    // An address below BASE fails the first compare. It is never allowed to
    // reach the span check through a wrapped subtraction.
    assign req_in_range = (req_addr >= BASE) && ({1'b0, req_addr - BASE} < SPAN);
    assign req_idx      = IDX_W'((req_addr - BASE) >> 2);

`ifdef YSYX_25020047_SRAM_RAND_LAT_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1. It runs every cycle regardless of
    // traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // The wait loaded on accept is the base latency plus a 0..3 random extra.
    always_comb begin
        load_cnt = 9'(LATENCY) + {7'd0, lfsr[1:0]};
    end
`else
    // The wait loaded on accept is exactly the configured latency.
    always_comb begin
        load_cnt = 9'(LATENCY);
    end
`endif

    // Request capture, wait countdown and response generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 9'd0;
            wen_q      <= 1'b0;
            wdata_q    <= 32'd0;
            wmask_q    <= 4'd0;
            in_range_q <= 1'b0;
            idx_q      <= '0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        wen_q      <= req_wen;
                        wdata_q    <= req_wdata;
                        wmask_q    <= req_wmask;
                        in_range_q <= req_in_range;
                        idx_q      <= req_idx;
                        cnt        <= load_cnt;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 9'd0) begin
                        state     <= S_RESP;
                        rsp_err   <= ~in_range_q;
                        rsp_rdata <= (!wen_q && in_range_q) ? mem[idx_q] : 32'd0;
                    end else begin
                        cnt <= cnt - 9'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The byte-masked write commits on the same edge that raises the response.
    // A reset during WAIT returns the state to IDLE, so an uncommitted write is
    // dropped.
    always_ff @(posedge clk) begin
        if (do_access && wen_q && in_range_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25020047_sram_resp.sv
// tb_ysyx_25020047_sram_resp
// Randomized self-checking bench for the SRAM responder. A word-array reference
// model predicts read data, error flags and response timing from the address
// map and the byte-mask rules. A second instance with LATENCY=0 covers the
// shortest path. Honours YSYX_25020047_SRAM_RAND_LAT_EN for latency windows.

module tb_ysyx_25020047_sram_resp;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        z_req_valid;
    logic        z_req_ready;
    logic [31:0] z_req_addr;
    logic        z_req_wen;
    logic [31:0] z_req_wdata;
    logic [3:0]  z_req_wmask;
    logic        z_rsp_valid;
    logic        z_rsp_ready;
    logic [31:0] z_rsp_rdata;
    logic        z_rsp_err;

    int          vectorCount;
    int          missCount;
    logic [31:0] model [DEPTH];

    ysyx_25020047_sram_resp #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wen   (req_wen),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    ysyx_25020047_sram_resp #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(0)) dutZero (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (z_req_valid),
        .req_ready (z_req_ready),
        .req_addr  (z_req_addr),
        .req_wen   (z_req_wen),
        .req_wdata (z_req_wdata),
        .req_wmask (z_req_wmask),
        .rsp_valid (z_rsp_valid),
        .rsp_ready (z_rsp_ready),
        .rsp_rdata (z_rsp_rdata),
        .rsp_err   (z_rsp_err)
    );

    // free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // hard stop if the stimulus ever stalls
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // single comparison point: counts every check, reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // address map of the reference memory
    function automatic logic inRange(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8000_1000);
    endfunction

    function automatic int wordOf(input logic [31:0] a);
        return int'((a - 32'h8000_0000) / 4) % DEPTH;
    endfunction

    // full transaction on the main instance, with response held off for 'hold' cycles
    task automatic applyStimulus(input string tag, input logic wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wmask, input int hold);
        logic [31:0] expData;
        logic        expErr;
        logic [31:0] heldData;
        logic        heldErr;
        int          w;
        int          n;
        expErr  = !inRange(addr);
        w       = wordOf(addr);
        expData = (!wen && !expErr) ? model[w] : 32'd0;
        checkOutput({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wen   = $urandom_range(0, 1);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wmask = 4'($urandom_range(0, 15));
        if (wen && !expErr) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) model[w][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        checkOutput({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rsp_valid) begin
            checkOutput({tag, " response timeout"}, 32'd0, 32'd1);
            return;
        end
`ifdef YSYX_25020047_SRAM_RAND_LAT_EN
        checkOutput({tag, " latency window"}, 32'((n >= LAT + 1) && (n <= LAT + 4)), 32'd1);
`else
        checkOutput({tag, " latency"}, 32'(n), 32'(LAT + 1));
`endif
        checkOutput({tag, " rdata"}, rsp_rdata, expData);
        checkOutput({tag, " err"}, 32'(rsp_err), 32'(expErr));
        checkOutput({tag, " req_ready resp"}, 32'(req_ready), 32'd0);
        heldData = rsp_rdata;
        heldErr  = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
            checkOutput({tag, " hold rdata"}, rsp_rdata, heldData);
            checkOutput({tag, " hold err"}, 32'(rsp_err), 32'(heldErr));
            checkOutput({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkOutput({tag, " done valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, " done req_ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, " done rdata"}, rsp_rdata, 32'd0);
        checkOutput({tag, " done err"}, 32'(rsp_err), 32'd0);
    endtask

    // transaction on the zero-latency instance, rsp_ready tied high
    task automatic zeroTxn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rdata);
        z_req_valid = 1'b1;
        z_req_wen   = wen;
        z_req_addr  = addr;
        z_req_wdata = wdata;
        z_req_wmask = 4'hF;
        z_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        z_req_valid = 1'b0;
        lat = 0;
        rdata = 32'd0;
        while (!z_rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = z_rsp_rdata;
        @(posedge clk);
        #1;
    endtask

    // main stimulus sequence
    initial begin
        logic [31:0] zData;
        int          zLat;
        vectorCount = 0;
        missCount   = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_wen     = 1'b0;
        req_addr    = 32'd0;
        req_wdata   = 32'd0;
        req_wmask   = 4'd0;
        rsp_ready   = 1'b0;
        z_req_valid = 1'b0;
        z_req_wen   = 1'b0;
        z_req_addr  = 32'd0;
        z_req_wdata = 32'd0;
        z_req_wmask = 4'd0;
        z_rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;

        #12;
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("wr deadbeef", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0);
        applyStimulus("rd deadbeef", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 0);
        applyStimulus("wr byte1", 1'b1, 32'h8000_0013, 32'h0000_5500, 4'b0010, 0);
        applyStimulus("rd dead55ef", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 0);
        checkOutput("model dead55ef", model[4], 32'hDEAD_55EF);

        for (int i = 0; i < 64; i++) begin
            if (i != 4) applyStimulus("init", 1'b1, BASE + 32'(i * 4), $urandom, 4'hF, 0);
        end
        applyStimulus("init top", 1'b1, BASE + 32'((DEPTH - 1) * 4), $urandom, 4'hF, 0);

        applyStimulus("rd backpressure", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 5);

        applyStimulus("wr below base", 1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0);
        applyStimulus("rd past end", 1'b0, 32'h8000_1000, 32'd0, 4'h0, 0);
        applyStimulus("rd word0", 1'b0, 32'h8000_0000, 32'd0, 4'h0, 0);
        applyStimulus("rd word1023", 1'b0, 32'h8000_0FFC, 32'd0, 4'h0, 0);

        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'h8000_0020;
        req_wdata = 32'h1234_5678;
        req_wmask = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst req_ready", 32'(req_ready), 32'd1);
        checkOutput("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("midrst rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("rd after midrst", 1'b0, 32'h8000_0020, 32'd0, 4'h0, 0);

        applyStimulus("wr mask0", 1'b1, 32'h8000_0014, 32'hA5A5_A5A5, 4'h0, 0);
        applyStimulus("rd mask0", 1'b0, 32'h8000_0014, 32'd0, 4'h0, 0);

        for (int k = 0; k < 50; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus("rnd wr", 1'b1, BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3)),
                              $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
            end
            applyStimulus("rnd rd", 1'b0, BASE + 32'($urandom_range(0, 63) * 4), 32'd0, 4'h0,
                          int'($urandom_range(0, 2)));
        end

        zeroTxn(1'b1, 32'h8000_0008, 32'hCAFE_F00D, zLat, zData);
`ifdef YSYX_25020047_SRAM_RAND_LAT_EN
        checkOutput("lat0 wr window", 32'((zLat >= 1) && (zLat <= 4)), 32'd1);
`else
        checkOutput("lat0 wr latency", 32'(zLat), 32'd1);
`endif
        zeroTxn(1'b0, 32'h8000_0008, 32'd0, zLat, zData);
`ifdef YSYX_25020047_SRAM_RAND_LAT_EN
        checkOutput("lat0 rd window", 32'((zLat >= 1) && (zLat <= 4)), 32'd1);
`else
        checkOutput("lat0 rd latency", 32'(zLat), 32'd1);
`endif
        checkOutput("lat0 rd data", zData, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
